// File: rtl/s64x7_bus_pkg.sv
// Shared definitions for the S64X7 two-master bus arbiter: state encoding,
// master identifiers and bus field widths.
package s64x7_bus_pkg;

    localparam int ADR_W = 61;
    localparam int DAT_W = 64;
    localparam int SEL_W = 8;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_GNT0 = 2'd1,
        ARB_GNT1 = 2'd2
    } arb_state_t;

    typedef logic master_id_t;

    localparam master_id_t M0 = 1'b0;
    localparam master_id_t M1 = 1'b1;

    function automatic arb_state_t grant_state(input master_id_t id);
        return (id == M0) ? ARB_GNT0 : ARB_GNT1;
    endfunction

endpackage

// File: rtl/s64x7_bus_watchdog.sv
// Ack watchdog: counts strobe cycles without ack and flags a one-cycle
// timeout when the wait reaches TIMEOUT_CYCLES.
module s64x7_bus_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic clk_i,
    input  logic reset_ni,
    input  logic stb,
    input  logic ack,
    input  logic clr,
    output logic timeout_o
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] count;

    // Ack in the terminal cycle suppresses the timeout.
    assign timeout_o = stb && !ack && (count == LAST_WAIT);

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            count <= '0;
        end else if (clr || !stb || ack || timeout_o) begin
            count <= '0;
        end else begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/s64x7_bus_arbiter.sv
// Two-master arbiter for the S64X7 memory bus with registered grant,
// whole-cycle lock, configurable tie-break and an ack watchdog.
//
//   state    | meaning
//   ---------+------------------------------------------------
//   ARB_IDLE | no master owns the bus, slave controls held 0
//   ARB_GNT0 | m0 (core) owns the bus until it drops cyc
//   ARB_GNT1 | m1 (secondary) owns the bus until it drops cyc
module s64x7_bus_arbiter
    import s64x7_bus_pkg::*;
#(
    parameter bit          FIXED_PRIORITY = 1'b0,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic             clk_i,
    input  logic             reset_ni,

    input  logic             m0_cyc_i,
    input  logic             m0_stb_i,
    input  logic             m0_we_i,
    input  logic             m0_vpa_i,
    input  logic [SEL_W-1:0] m0_sel_i,
    input  logic [ADR_W-1:0] m0_adr_i,
    input  logic [DAT_W-1:0] m0_dat_i,
    output logic             m0_ack_o,
    output logic             m0_err_o,

    input  logic             m1_cyc_i,
    input  logic             m1_stb_i,
    input  logic             m1_we_i,
    input  logic [SEL_W-1:0] m1_sel_i,
    input  logic [ADR_W-1:0] m1_adr_i,
    input  logic [DAT_W-1:0] m1_dat_i,
    output logic             m1_ack_o,
    output logic             m1_err_o,

    output logic [DAT_W-1:0] dat_o,

    output logic             s_cyc_o,
    output logic             s_stb_o,
    output logic             s_we_o,
    output logic             s_vpa_o,
    output logic [SEL_W-1:0] s_sel_o,
    output logic [ADR_W-1:0] s_adr_o,
    output logic [DAT_W-1:0] s_dat_o,
    input  logic             s_ack_i,
    input  logic [DAT_W-1:0] s_dat_i
);

    arb_state_t state, state_next;
    master_id_t last_grant, last_grant_next;
    logic       timeout;

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state      <= ARB_IDLE;
            last_grant <= M1;
        end else begin
            state      <= state_next;
            last_grant <= last_grant_next;
        end
    end

    always_comb begin
        state_next      = state;
        last_grant_next = last_grant;
        case (state)
            ARB_IDLE: begin
                if (m0_cyc_i && m1_cyc_i) begin
                    state_next = (FIXED_PRIORITY || last_grant == M1) ? ARB_GNT0 : ARB_GNT1;
                end else if (m0_cyc_i) begin
                    state_next = ARB_GNT0;
                end else if (m1_cyc_i) begin
                    state_next = ARB_GNT1;
                end
            end
            ARB_GNT0: begin
                if (!m0_cyc_i) begin
                    state_next = m1_cyc_i ? ARB_GNT1 : ARB_IDLE;
                end
            end
            ARB_GNT1: begin
                if (!m1_cyc_i) begin
                    state_next = m0_cyc_i ? ARB_GNT0 : ARB_IDLE;
                end
            end
            default: state_next = ARB_IDLE;
        endcase
        if (state_next == grant_state(M0)) begin
            last_grant_next = M0;
        end else if (state_next == grant_state(M1)) begin
            last_grant_next = M1;
        end
    end

    // Slave side follows the owner combinationally so a dropped cyc is seen immediately.
    always_comb begin
        s_cyc_o  = 1'b0;
        s_stb_o  = 1'b0;
        s_we_o   = 1'b0;
        s_vpa_o  = 1'b0;
        s_sel_o  = '0;
        s_adr_o  = '0;
        s_dat_o  = '0;
        m0_ack_o = 1'b0;
        m0_err_o = 1'b0;
        m1_ack_o = 1'b0;
        m1_err_o = 1'b0;
        case (state)
            ARB_GNT0: begin
                s_cyc_o  = m0_cyc_i;
                s_stb_o  = m0_stb_i;
                s_we_o   = m0_we_i;
                s_vpa_o  = m0_vpa_i;
                s_sel_o  = m0_sel_i;
                s_adr_o  = m0_adr_i;
                s_dat_o  = m0_dat_i;
                m0_ack_o = s_ack_i;
                m0_err_o = timeout;
            end
            ARB_GNT1: begin
                s_cyc_o  = m1_cyc_i;
                s_stb_o  = m1_stb_i;
                s_we_o   = m1_we_i;
                s_sel_o  = m1_sel_i;
                s_adr_o  = m1_adr_i;
                s_dat_o  = m1_dat_i;
                m1_ack_o = s_ack_i;
                m1_err_o = timeout;
            end
            default: ;
        endcase
    end

    assign dat_o = s_dat_i;

    s64x7_bus_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk_i    (clk_i),
        .reset_ni (reset_ni),
        .stb      (s_stb_o),
        .ack      (s_ack_i),
        .clr      (state_next != state),
        .timeout_o(timeout)
    );

endmodule
